// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller and its emergency arbiter:
// direction codes, arbiter state encoding, signal-head colours and timebase.
package traffic_pkg;

  localparam int unsigned ONE_SECOND = 50;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_SERVE    = 2'd2,
    ST_COOLDOWN = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_e;

  // One-hot mask for a direction code.
  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    dir_onehot = 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: the first set request after ptr
// wins, scanning ptr+1, ptr+2, ptr+3 and finally ptr itself.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);
  import traffic_pkg::*;

  logic [1:0] cand;

  // Scan from the farthest offset to the nearest so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k) + 2'd1;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/emergency_preempt_arbiter.sv
// Emergency-vehicle preemption arbiter. Picks one approach round-robin, holds
// all approaches red for a clearance interval, serves the winner between a
// minimum and maximum time, then enforces an all-red cooldown. A direction
// that runs out the maximum while still requesting is locked out until its
// request drops.
module emergency_preempt_arbiter #(
  parameter int unsigned ONE_SECOND    = traffic_pkg::ONE_SECOND,
  parameter int unsigned CLEAR_TIME    = 2,
  parameter int unsigned MIN_SERVE     = 5,
  parameter int unsigned MAX_SERVE     = 30,
  parameter int unsigned COOLDOWN_TIME = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  emg_req,
  output logic        emergency_override,
  output logic [1:0]  emergency_direction,
  output logic        all_red_hold,
  output logic [3:0]  grant,
  output logic [3:0]  lockout,
  output logic [1:0]  arb_state,
  output logic [31:0] emg_timer
);
  import traffic_pkg::*;

  localparam logic [31:0] D_CLEAR = 32'(CLEAR_TIME * ONE_SECOND);
  localparam logic [31:0] D_MIN   = 32'(MIN_SERVE * ONE_SECOND);
  localparam logic [31:0] D_MAX   = 32'(MAX_SERVE * ONE_SECOND);
  localparam logic [31:0] D_COOL  = 32'(COOLDOWN_TIME * ONE_SECOND);

  arb_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  lockout_q, lockout_d;
  logic        override_q, override_d;
  logic        all_red_q, all_red_d;
  logic [3:0]  grant_q, grant_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] dur;

  logic [3:0]  eligible;
  logic        pick_valid;
  logic [1:0]  pick_idx;

  assign eligible = emg_req & ~lockout_q;

  rr_pick4 u_pick (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state, counter, winner, round-robin pointer and lockout update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    dir_d     = dir_q;
    rr_ptr_d  = rr_ptr_q;
    lockout_d = lockout_q & emg_req;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          dir_d   = pick_idx;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // A request withdrawn during clearance is abandoned, never served.
        if (!emg_req[dir_q]) begin
          state_d  = ST_COOLDOWN;
          cnt_d    = '0;
          rr_ptr_d = dir_q;
        end else if (cnt_q == D_CLEAR - 32'd1) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end
      end
      ST_SERVE: begin
        if (cnt_q == D_MAX - 32'd1) begin
          state_d  = ST_COOLDOWN;
          cnt_d    = '0;
          rr_ptr_d = dir_q;
          if (emg_req[dir_q]) lockout_d[dir_q] = 1'b1;
        end else if (!emg_req[dir_q] && (cnt_q >= D_MIN - 32'd1)) begin
          state_d  = ST_COOLDOWN;
          cnt_d    = '0;
          rr_ptr_d = dir_q;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == D_COOL - 32'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the state being entered, so outputs are registered.
  always_comb begin
    override_d = (state_d == ST_SERVE);
    all_red_d  = (state_d == ST_CLEAR) || (state_d == ST_COOLDOWN);
    grant_d    = ((state_d == ST_CLEAR) || (state_d == ST_SERVE)) ? dir_onehot(dir_d) : 4'd0;
    case (state_d)
      ST_CLEAR:    dur = D_CLEAR;
      ST_SERVE:    dur = D_MAX;
      ST_COOLDOWN: dur = D_COOL;
      default:     dur = '0;
    endcase
    timer_d = (state_d == ST_IDLE) ? 32'd0 : (dur - cnt_d) / ONE_SECOND;
  end

  // State and output registers; reset abandons any grant immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_q      <= DIR_N;
      rr_ptr_q   <= DIR_W;
      lockout_q  <= '0;
      override_q <= 1'b0;
      all_red_q  <= 1'b0;
      grant_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      rr_ptr_q   <= rr_ptr_d;
      lockout_q  <= lockout_d;
      override_q <= override_d;
      all_red_q  <= all_red_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
    end
  end

  assign emergency_override  = override_q;
  assign emergency_direction = dir_q;
  assign all_red_hold        = all_red_q;
  assign grant               = grant_q;
  assign lockout             = lockout_q;
  assign arb_state           = state_q;
  assign emg_timer           = timer_q;

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Bench for emergency_preempt_arbiter: hand-derived vector table for the
// directed scenarios, then randomized requests against a behavioural model.
module tb_emergency_preempt_arbiter;

  localparam int OS = 50;
  localparam int CT = 2;
  localparam int MS = 5;
  localparam int XS = 30;
  localparam int CD = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  emg_req;
  logic        emergency_override;
  logic [1:0]  emergency_direction;
  logic        all_red_hold;
  logic [3:0]  grant;
  logic [3:0]  lockout;
  logic [1:0]  arb_state;
  logic [31:0] emg_timer;

  emergency_preempt_arbiter #(
    .ONE_SECOND(OS), .CLEAR_TIME(CT), .MIN_SERVE(MS),
    .MAX_SERVE(XS), .COOLDOWN_TIME(CD)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .emg_req             (emg_req),
    .emergency_override  (emergency_override),
    .emergency_direction (emergency_direction),
    .all_red_hold        (all_red_hold),
    .grant               (grant),
    .lockout             (lockout),
    .arb_state           (arb_state),
    .emg_timer           (emg_timer)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: phase 0..3 = idle/clear/serve/cooldown, counted in
  // cycles already spent in the phase.
  int         m_phase;
  int         m_spent;
  int         m_dir;
  int         m_last;
  logic [3:0] m_lock;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    int          n;
    logic [1:0]  st;
    logic        ovr;
    logic        ar;
    logic [1:0]  dir;
    logic [3:0]  gnt;
    logic [3:0]  lk;
    logic [31:0] tmr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [45:0] dut_vec();
    return {arb_state, emergency_override, all_red_hold, emergency_direction,
            grant, lockout, emg_timer};
  endfunction

  function automatic int phase_len(input int ph);
    case (ph)
      1:       return CT * OS;
      2:       return XS * OS;
      3:       return CD * OS;
      default: return 0;
    endcase
  endfunction

  function automatic logic [45:0] model_vec();
    logic [1:0]  st;
    logic [3:0]  g;
    logic [31:0] t;
    st = 2'(m_phase);
    g  = (m_phase == 1 || m_phase == 2) ? 4'(1 << m_dir) : 4'd0;
    t  = (m_phase == 0) ? 32'd0 : 32'((phase_len(m_phase) - m_spent) / OS);
    return {st, (m_phase == 2), (m_phase == 1 || m_phase == 3), 2'(m_dir), g, m_lock, t};
  endfunction

  task automatic check(input string name, input logic [45:0] act, input logic [45:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got st/ovr/ar/dir/gnt/lk/tmr=%h expected=%h", name, cyc, act, exp);
      if (errors >= 200) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] q);
    logic [3:0] elig;
    logic [3:0] nl;
    int         c;
    if (r) begin
      m_phase = 0; m_spent = 0; m_dir = 0; m_last = 3; m_lock = 4'd0;
      return;
    end
    nl = m_lock & q;
    case (m_phase)
      0: begin
        elig = q & ~m_lock;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (elig[c] && m_phase == 0) begin
            m_dir = c;
            m_phase = 1;
          end
        end
        m_spent = 0;
      end
      1: begin
        if (!q[m_dir]) begin
          m_phase = 3; m_spent = 0; m_last = m_dir;
        end else if (m_spent + 1 == CT * OS) begin
          m_phase = 2; m_spent = 0;
        end else m_spent++;
      end
      2: begin
        if (m_spent + 1 == XS * OS) begin
          if (q[m_dir]) nl[m_dir] = 1'b1;
          m_phase = 3; m_spent = 0; m_last = m_dir;
        end else if (!q[m_dir] && m_spent + 1 >= MS * OS) begin
          m_phase = 3; m_spent = 0; m_last = m_dir;
        end else m_spent++;
      end
      default: begin
        if (m_spent + 1 == CD * OS) begin
          m_phase = 0; m_spent = 0;
        end else m_spent++;
      end
    endcase
    m_lock = nl;
  endtask

  task automatic tick(input logic r, input logic [3:0] q);
    reset   = r;
    emg_req = q;
    @(posedge clk);
    model_step(r, q);
    cyc++;
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic add(input logic r, input logic [3:0] q, input int n,
                     input logic [1:0] st, input logic ovr, input logic ar,
                     input logic [1:0] dir, input logic [3:0] gnt,
                     input logic [3:0] lk, input logic [31:0] tmr);
    vec_t v;
    v.rst = r; v.req = q; v.n = n; v.st = st; v.ovr = ovr; v.ar = ar;
    v.dir = dir; v.gnt = gnt; v.lk = lk; v.tmr = tmr;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] cur;
    logic       r;
    int         rate;
    reset   = 1'b1;
    emg_req = 4'd0;
    m_phase = 0; m_spent = 0; m_dir = 0; m_last = 3; m_lock = 4'd0;

    //   rst  req    n     st ovr ar dir gnt    lk     tmr
    add(1, 4'h0, 2,    0, 0, 0, 0, 4'h0, 4'h0, 0);   // reset state
    add(0, 4'h1, 1,    1, 0, 1, 0, 4'h1, 4'h0, 2);   // N alone -> CLEAR
    add(0, 4'h1, 50,   1, 0, 1, 0, 4'h1, 4'h0, 1);
    add(0, 4'h1, 49,   1, 0, 1, 0, 4'h1, 4'h0, 0);
    add(0, 4'h1, 1,    2, 1, 0, 0, 4'h1, 4'h0, 30);  // CLEAR lasted 100
    add(0, 4'h0, 1,    2, 1, 0, 0, 4'h1, 4'h0, 29);  // dropped: held to min
    add(0, 4'h0, 247,  2, 1, 0, 0, 4'h1, 4'h0, 25);
    add(0, 4'h0, 1,    2, 1, 0, 0, 4'h1, 4'h0, 25);
    add(0, 4'h0, 1,    3, 0, 1, 0, 4'h0, 4'h0, 1);   // SERVE lasted 250
    add(0, 4'h0, 49,   3, 0, 1, 0, 4'h0, 4'h0, 0);
    add(0, 4'h0, 1,    0, 0, 0, 0, 4'h0, 4'h0, 0);   // cooldown 50
    add(0, 4'hC, 1,    1, 0, 1, 2, 4'h4, 4'h0, 2);   // E+W -> E
    add(0, 4'hC, 100,  2, 1, 0, 2, 4'h4, 4'h0, 30);
    add(0, 4'h8, 250,  3, 0, 1, 2, 4'h0, 4'h0, 1);
    add(0, 4'h8, 50,   0, 0, 0, 2, 4'h0, 4'h0, 0);
    add(0, 4'h8, 1,    1, 0, 1, 3, 4'h8, 4'h0, 2);   // then W
    add(0, 4'h8, 100,  2, 1, 0, 3, 4'h8, 4'h0, 30);
    add(0, 4'h5, 250,  3, 0, 1, 3, 4'h0, 4'h0, 1);
    add(0, 4'h5, 50,   0, 0, 0, 3, 4'h0, 4'h0, 0);
    add(0, 4'h5, 1,    1, 0, 1, 0, 4'h1, 4'h0, 2);   // N+E -> N
    add(0, 4'h0, 1,    3, 0, 1, 0, 4'h0, 4'h0, 1);   // abort in CLEAR
    add(0, 4'h0, 50,   0, 0, 0, 0, 4'h0, 4'h0, 0);
    add(0, 4'h2, 1,    1, 0, 1, 1, 4'h2, 4'h0, 2);   // S held forever
    add(0, 4'h2, 100,  2, 1, 0, 1, 4'h2, 4'h0, 30);
    add(0, 4'h2, 1499, 2, 1, 0, 1, 4'h2, 4'h0, 0);
    add(0, 4'h2, 1,    3, 0, 1, 1, 4'h0, 4'h2, 1);   // forced release
    add(0, 4'h2, 50,   0, 0, 0, 1, 4'h0, 4'h2, 0);
    add(0, 4'h2, 10,   0, 0, 0, 1, 4'h0, 4'h2, 0);   // locked, not re-granted
    add(0, 4'h0, 1,    0, 0, 0, 1, 4'h0, 4'h0, 0);   // lockout clears
    add(0, 4'h2, 1,    1, 0, 1, 1, 4'h2, 4'h0, 2);
    add(0, 4'h2, 100,  2, 1, 0, 1, 4'h2, 4'h0, 30);
    add(0, 4'h2, 20,   2, 1, 0, 1, 4'h2, 4'h0, 29);
    add(1, 4'h2, 1,    0, 0, 0, 0, 4'h0, 4'h0, 0);   // reset mid-SERVE
    add(0, 4'h2, 1,    1, 0, 1, 1, 4'h2, 4'h0, 2);   // restarts from CLEAR
    add(0, 4'h2, 40,   1, 0, 1, 1, 4'h2, 4'h0, 1);
    add(0, 4'h0, 1,    3, 0, 1, 1, 4'h0, 4'h0, 1);   // drop at CLEAR cycle 40
    add(0, 4'h0, 50,   0, 0, 0, 1, 4'h0, 4'h0, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].rst, tbl[i].req);
      check($sformatf("row%0d", i), dut_vec(),
            {tbl[i].st, tbl[i].ovr, tbl[i].ar, tbl[i].dir, tbl[i].gnt, tbl[i].lk, tbl[i].tmr});
    end

    // Randomized slow-moving requests with occasional reset.
    cur = 4'd0;
    for (int c = 0; c < 40000; c++) begin
      rate = (c < 20000) ? 300 : 1200;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(rate - 1) == 0) cur[b] = ~cur[b];
      r = ($urandom_range(9999) == 0);
      tick(r, cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
